// File: rtl/aes256_pkg.sv
// Shared AES-256 constants: S-box, round constants, schedule sizes and the
// key-expansion FSM state type.
package aes256_pkg;

  localparam int NK = 8;
  localparam int NR = 14;
  localparam int NW = 60;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is never used: the first round constant applies to w[8] (i/8 == 1).
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

endpackage

// File: rtl/aes256_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word (purely combinational).
module aes256_subword
  import aes256_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                   SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: one word per cycle into a 60x32 flop store, with a
// registered round-key read port usable in any state.
module aes256_key_expand
  import aes256_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [255:0] key_i,
  input  logic [3:0]   rk_idx_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_valid_o,
  output logic [127:0] rk_o
);

  state_t       state_q, state_d;
  logic [5:0]   wIdx_q, wIdx_d;
  logic         done_q, done_d;
  logic [127:0] rk_q, rk_d;
  logic [31:0]  w_q [NW];

  logic         loadKey, writeWord, lastWord;
  logic [31:0]  prevWord, subIn, subOut, tWord, newWord;
  logic [5:0]   rkBase;

  aes256_subword u_subword (
    .word_i (subIn),
    .word_o (subOut)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wIdx_q  <= '0;
      done_q  <= 1'b0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      wIdx_q  <= wIdx_d;
      done_q  <= done_d;
      rk_q    <= rk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wIdx_d    = wIdx_q;
    done_d    = 1'b0;
    loadKey   = 1'b0;
    writeWord = 1'b0;
    lastWord  = (wIdx_q == 6'(NW - 1));
    case (state_q)
      IDLE, READY: begin
        if (start_i) begin
          loadKey = 1'b1;
          state_d = EXPAND;
          wIdx_d  = 6'(NK);
        end
      end
      EXPAND: begin
        writeWord = 1'b1;
        // Counter holds at the last index rather than wrapping.
        if (lastWord) begin
          state_d = READY;
          done_d  = 1'b1;
        end else begin
          wIdx_d = wIdx_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prevWord = w_q[wIdx_q - 6'd1];
    subIn    = (wIdx_q[2:0] == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
    case (wIdx_q[2:0])
      3'd0:    tWord = subOut ^ {RCON[wIdx_q[5:3]], 24'h0};
      3'd4:    tWord = subOut;
      default: tWord = prevWord;
    endcase
    newWord = w_q[wIdx_q - 6'(NK)] ^ tWord;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (loadKey) begin
      for (int k = 0; k < NK; k++) w_q[k] <= key_i[255 - 32*k -: 32];
    end else if (writeWord) begin
      w_q[wIdx_q] <= newWord;
    end
  end

  always_comb begin
    rkBase = {rk_idx_i, 2'b00};
    rk_d   = '0;
    if (rk_idx_i <= 4'(NR)) begin
      rk_d = {w_q[rkBase], w_q[rkBase + 6'd1], w_q[rkBase + 6'd2], w_q[rkBase + 6'd3]};
    end
  end

  assign busy_o       = (state_q == EXPAND);
  assign keys_valid_o = (state_q == READY);
  assign done_o       = done_q;
  assign rk_o         = rk_q;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Self-checking bench for aes256_key_expand against a reference schedule built
// from GF(2^8) arithmetic, plus FIPS-197 vectors.
module tb_aes256_key_expand;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [255:0] key_i = '0;
  logic [3:0]   rk_idx_i = '0;
  logic         busy_o, done_o, keys_valid_o;
  logic [127:0] rk_o;

  int total = 0;
  int bad = 0;

  logic [7:0]   sboxM [256];
  logic [127:0] modelRk [15];
  logic [127:0] obsRk [15];

  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes256_key_expand dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .key_i        (key_i),
    .rk_idx_i     (rk_idx_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .keys_valid_o (keys_valid_o),
    .rk_o         (rk_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxM[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWordM(input logic [31:0] v);
    return {sboxM[v[31:24]], sboxM[v[23:16]], sboxM[v[15:8]], sboxM[v[7:0]]};
  endfunction

  task automatic buildModel(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = subWordM({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        temp = subWordM(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int k = 0; k < 15; k++) modelRk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one edge, then checks the state the start edge produced.
  task automatic applyStimulus(input logic [255:0] key, input string tag);
    @(negedge clk_i);
    key_i   = key;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput({tag, "_busy_after_start"}, 256'(busy_o), 256'(1));
    checkOutput({tag, "_valid_after_start"}, 256'(keys_valid_o), 256'(0));
    checkOutput({tag, "_done_after_start"}, 256'(done_o), 256'(0));
  endtask

  // Runs 60 edges after the start edge, counting done pulses; optionally
  // injects a second start or an asynchronous reset at a given edge.
  task automatic runExpansion(input string tag, input int injectAt, input logic [255:0] key2,
                              input int resetAt, input int expPulses);
    int firstDone = -1;
    int pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin
        pulses++;
        if (firstDone < 0) firstDone = n;
      end
      if (n == injectAt) begin
        key_i   = key2;
        start_i = 1'b1;
      end
      if (n == resetAt) begin
        #2 rst_i = 1'b1;
        #1;
        checkOutput({tag, "_rst_busy"}, 256'(busy_o), 256'(0));
        checkOutput({tag, "_rst_done"}, 256'(done_o), 256'(0));
        checkOutput({tag, "_rst_valid"}, 256'(keys_valid_o), 256'(0));
        checkOutput({tag, "_rst_rk"}, 256'(rk_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        return;
      end
    end
    if (expPulses > 0) begin
      checkOutput({tag, "_done_edge"}, 256'(firstDone), 256'(52));
      checkOutput({tag, "_valid_level"}, 256'(keys_valid_o), 256'(1));
      checkOutput({tag, "_busy_level"}, 256'(busy_o), 256'(0));
    end
    checkOutput({tag, "_done_pulses"}, 256'(pulses), 256'(expPulses));
  endtask

  task automatic sweepKeys(input string tag);
    for (int k = 14; k >= 0; k--) begin
      @(negedge clk_i);
      rk_idx_i = 4'(k);
      @(negedge clk_i);
      obsRk[k] = rk_o;
      checkOutput($sformatf("%s_rk%0d", tag, k), 256'(rk_o), 256'(modelRk[k]));
    end
    @(negedge clk_i);
    rk_idx_i = 4'd15;
    @(negedge clk_i);
    checkOutput({tag, "_rk15_zero"}, 256'(rk_o), 256'(0));
  endtask

  initial begin
    logic [255:0] rndKey;
    buildSbox();

    #12;
    checkOutput("reset_busy", 256'(busy_o), 256'(0));
    checkOutput("reset_done", 256'(done_o), 256'(0));
    checkOutput("reset_valid", 256'(keys_valid_o), 256'(0));
    checkOutput("reset_rk", 256'(rk_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    buildModel(KEY_A3);
    applyStimulus(KEY_A3, "a3");
    runExpansion("a3", -1, '0, -1, 1);
    sweepKeys("a3");
    checkOutput("a3_w8", 256'(obsRk[2][127:96]), 256'(32'h9ba35411));
    checkOutput("a3_rk14_fips", 256'(obsRk[14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));

    // Restart from READY without reset
    buildModel(KEY_C3);
    applyStimulus(KEY_C3, "c3");
    runExpansion("c3", -1, '0, -1, 1);
    sweepKeys("c3");
    checkOutput("c3_rk0_fips", 256'(obsRk[0]), 256'(128'h000102030405060708090a0b0c0d0e0f));
    checkOutput("c3_rk14_fips", 256'(obsRk[14]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));

    buildModel(KEY_A3);
    applyStimulus(KEY_A3, "ign");
    runExpansion("ign", 10, KEY_C3, -1, 1);
    sweepKeys("ign");

    applyStimulus(KEY_C3, "midrst");
    runExpansion("midrst", -1, '0, 30, 0);
    buildModel(KEY_A3);
    applyStimulus(KEY_A3, "post_rst");
    runExpansion("post_rst", -1, '0, -1, 1);
    sweepKeys("post_rst");

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) rndKey[255 - 32*j -: 32] = $urandom;
      buildModel(rndKey);
      applyStimulus(rndKey, $sformatf("rnd%0d", r));
      runExpansion($sformatf("rnd%0d", r), -1, '0, -1, 1);
      sweepKeys($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
